// File: rtl/merge_feeder.sv
// Serial-to-4-lane packer feeding the merge sorting network: frames the input
// stream to the selected constellation size and tags the final packed word.
module merge_feeder #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         s,
  input  logic               start,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]         state_q,     state_d;
  logic [1:0]         size_q,      size_d;
  logic [1:0]         lane_q,      lane_d;
  logic [8:0]         elem_q,      elem_d;
  logic [3*WIDTH-1:0] pack_q,      pack_d;
  logic [4*WIDTH-1:0] out_data_q,  out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q,  out_last_d;
  logic               done_q,      done_d;

  logic [8:0] last_idx;
  logic       slot_ok;
  logic       consume;
  logic       accept;
  logic       in_ready_c;

  always_comb begin
    case (size_q)
      2'b00:   last_idx = 9'd3;
      2'b01:   last_idx = 9'd15;
      2'b10:   last_idx = 9'd63;
      default: last_idx = 9'd255;
    endcase
  end

  // Lanes 0..2 only touch the pack register; only the 4th element needs the output slot.
  assign slot_ok    = !out_valid_q || out_ready;
  assign consume    = out_valid_q && out_ready;
  assign in_ready_c = (state_q == FILL) && ((lane_q != 2'd3) || slot_ok);
  assign accept     = in_valid && in_ready_c;

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    lane_d      = lane_q;
    elem_d      = elem_q;
    pack_d      = pack_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          size_d  = s;
          lane_d  = '0;
          elem_d  = '0;
        end
      end

      FILL: begin
        if (consume) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
        if (accept) begin
          lane_d = lane_q + 2'd1;
          elem_d = elem_q + 9'd1;
          // A load on the same edge as a consume overrides the clear above.
          if (lane_q == 2'd3) begin
            out_data_d  = {in_data, pack_q};
            out_valid_d = 1'b1;
            out_last_d  = (elem_q == last_idx);
          end else begin
            pack_d[lane_q*WIDTH +: WIDTH] = in_data;
          end
          if (elem_q == last_idx) begin
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        if (consume) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = IDLE;
          done_d      = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      size_q      <= '0;
      lane_q      <= '0;
      elem_q      <= '0;
      pack_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      lane_q      <= lane_d;
      elem_q      <= elem_d;
      pack_q      <= pack_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_merge_feeder.sv
// Bench for merge_feeder: directed frames with randomized handshakes, checked
// against a queue-based model of accepted elements and packed words.
module tb_merge_feeder;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     s;
  logic           start;
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic [4*W-1:0] out_data;
  logic           out_valid;
  logic           out_ready;
  logic           out_last;
  logic           busy;
  logic           done;

  always #5 clk = ~clk;

  merge_feeder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .s(s), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  typedef struct {
    logic [4*W-1:0] data;
    logic           last;
  } word_t;

  int checks = 0;
  int errors = 0;

  word_t        wq[$];
  logic [W-1:0] acc[$];
  bit           busy_m, done_m;
  int           frame_n, fed_n;
  int           words_seen, lasts_seen, dones_seen, frame_words, steps_n;
  logic [4*W-1:0] first_word, last_word;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    wq.delete();
    acc.delete();
    busy_m = 0;
    done_m = 0;
    fed_n  = 0;
  endtask

  task automatic chk_zero();
    chk("rst_in_ready",  in_ready,  0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last",  out_last,  0);
    chk("rst_busy",      busy,      0);
    chk("rst_done",      done,      0);
  endtask

  // One clock: drive at negedge, check against model, then advance the model over the next edge.
  task automatic step(input bit st, input logic [1:0] sel, input bit iv,
                      input logic [W-1:0] d, input bit ordy);
    bit    bsy0, fill, exp_rdy, consume, accept;
    word_t w;
    @(negedge clk);
    start = st; s = sel; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    bsy0    = busy_m;
    fill    = busy_m && (fed_n < frame_n);
    exp_rdy = fill && ((acc.size() != 3) || (wq.size() == 0) || ordy);
    chk("out_valid", out_valid, wq.size() != 0);
    if (wq.size() != 0) begin
      chk("out_data", out_data, wq[0].data);
      chk("out_last", out_last, wq[0].last);
    end
    chk("busy", busy, busy_m);
    chk("done", done, done_m);
    chk("in_ready", in_ready, exp_rdy);
    if (done === 1'b1) dones_seen++;
    consume = (wq.size() != 0) && ordy;
    accept  = iv && exp_rdy;
    done_m  = 0;
    if (consume) begin
      w = wq.pop_front();
      words_seen++;
      if (frame_words == 0) first_word = w.data;
      last_word = w.data;
      frame_words++;
      if (w.last) begin
        lasts_seen++;
        busy_m = 0;
        done_m = 1;
      end
    end
    if (accept) begin
      acc.push_back(d);
      fed_n++;
      if (acc.size() == 4) begin
        w.data = {acc[3], acc[2], acc[1], acc[0]};
        w.last = (fed_n == frame_n);
        wq.push_back(w);
        acc.delete();
      end
    end
    if (st && !bsy0) begin
      busy_m  = 1;
      frame_n = 4 << (2 * sel);
      fed_n   = 0;
    end
  endtask

  task automatic run_frame(input logic [1:0] sel, input int base, input bit rnd,
                           input int vpct, input int rpct, input int stall,
                           input bit noise, input int budget, input int abort_at);
    int w0, l0, d0, stall_left;
    bit iv, ordy, st;
    logic [1:0] sl;
    w0 = words_seen; l0 = lasts_seen; d0 = dones_seen;
    frame_words = 0; steps_n = 0; stall_left = stall;
    step(1'b1, sel, 1'b1, 8'hAA, 1'b1);
    while (busy_m && steps_n < budget && !(abort_at > 0 && fed_n >= abort_at)) begin
      iv = ($urandom_range(99) < vpct);
      if (wq.size() != 0 && stall_left > 0) begin
        ordy = 1'b0;
        stall_left--;
      end else begin
        ordy = ($urandom_range(99) < rpct);
      end
      st = noise && ($urandom_range(5) == 0);
      sl = noise ? 2'($urandom) : sel;
      step(st, sl, iv, rnd ? 8'($urandom) : 8'(fed_n + base), ordy);
      steps_n++;
    end
    if (abort_at == 0) begin
      chk("timeout", busy_m, 0);
      step(1'b0, sel, 1'b0, '0, 1'b1);
      chk("frame_words", words_seen - w0, frame_n / 4);
      chk("frame_lasts", lasts_seen - l0, 1);
      chk("frame_dones", dones_seen - d0, 1);
    end
  endtask

  initial begin
    rst = 1'b0; s = '0; start = 0; in_data = '0; in_valid = 0; out_ready = 0;
    words_seen = 0; lasts_seen = 0; dones_seen = 0; frame_words = 0;
    frame_n = 4; first_word = '0; last_word = '0;
    model_reset();
    #3;
    chk_zero();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 2'($urandom), 1'b1, 8'($urandom), 1'b1);

    run_frame(2'b00, 1, 0, 100, 100, 0, 0, 100, 0);
    chk("qpsk_word", last_word, 32'h04030201);

    run_frame(2'b01, 0, 0, 100, 100, 12, 0, 300, 0);
    chk("qam16_first", first_word, 32'h03020100);
    chk("qam16_last", last_word, 32'h0F0E0D0C);

    run_frame(2'b11, 0, 0, 100, 100, 0, 0, 2000, 0);
    chk("qam256_cycles", steps_n, 257);
    chk("qam256_last", last_word, 32'hFFFEFDFC);

    run_frame(2'b10, 0, 1, 70, 70, 0, 1, 3000, 0);

    for (int i = 0; i < 6; i++) run_frame(2'($urandom), 0, 1, 60, 60, 0, 1, 3000, 0);

    run_frame(2'b10, 0, 1, 100, 100, 0, 0, 1000, 37);
    @(posedge clk);
    start = 1'($urandom); in_valid = 1'b1; in_data = 8'($urandom); out_ready = 1'($urandom);
    #2;
    rst = 1'b0;
    #1;
    chk_zero();
    model_reset();
    for (int i = 0; i < 2; i++) step(1'b0, 2'($urandom), 1'b1, 8'($urandom), 1'b1);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 2'b00, 1'b1, 8'h55, 1'b1);
    run_frame(2'b00, 0, 1, 100, 100, 0, 0, 100, 0);
    chk("abort_words", frame_words, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/merge_feeder.md
Name: merge_feeder

Overview:
- Front-end packer for the merge sorting network.
- Accepts a serial stream of WIDTH-bit metrics with valid/ready.
- Packs them four per word into the network's 4-element input bus.
- Frames the stream to the constellation size selected at start and flags the last word, so the merge stages receive exactly one complete frame per run.

Parameters:
- WIDTH, 8, bits per element

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low (asserted at 0)
- s  in  2  frame size select, sampled on start: 00=4 (QPSK), 01=16 (QAM16), 10=64 (QAM64), 11=256 (QAM256) elements
- start  in  1  one-cycle request to begin a frame
- in_data  in  WIDTH  serial element
- in_valid  in  1  in_data valid
- in_ready  out  1  element accepted on clk edge when in_valid&in_ready
- out_data  out  4*WIDTH  packed word; element k at bits [(k+1)*WIDTH-1 : k*WIDTH], k=0 first received
- out_valid  out  1  out_data valid
- out_ready  in  1  word consumed on clk edge when out_valid&out_ready
- out_last  out  1  high with final word of frame
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after final word consumed

Behaviour:
- Reset (rst=0, async): all outputs 0, including out_data; FSM=IDLE, counters 0. Reset mid-frame discards partial and held words; there is no recovery of the frame.
- FSM states:
  - IDLE -> FILL on start (latch s into size register).
  - FILL -> DRAIN when the final element of the frame is accepted.
  - DRAIN -> IDLE when the final word is consumed; done pulses the cycle after that edge.
- busy=1 in FILL and DRAIN.
- start ignored in FILL/DRAIN. s changes after start ignored until next frame.
- in_ready=0 in IDLE and DRAIN. start and in_valid asserted in the same cycle: no element accepted that cycle.
- Lane counter lane (0..3) selects the pack-register slot; element count elem (9 bits, 0..255) counts accepted elements.
- in_ready in FILL:
  - 1 when lane!=3.
  - 1 when lane==3 and output slot free or freeing (!out_valid || out_ready).
  - Otherwise 0. Lanes 0..2 always accept; the 4th element waits for the slot.
- On acceptance of the lane-3 element:
  - Lanes 0..2 from the pack register plus in_data load out_data in one edge.
  - out_valid=1 next cycle; latency 1 cycle from 4th element.
  - out_last=1 if elem==size-1.
  - lane wraps to 0.
- Sustained throughput: 1 element/cycle when out_ready=1.
- While out_valid&!out_ready: out_data, out_last hold stable. Lanes 0..2 of the next word may still fill.
- Word consumed with no new word loading: out_valid, out_last -> 0 next cycle; out_data holds last value.
- Simultaneous consume and load on the same edge: the new word replaces the old one with no bubble.
- Word count per frame: 1/4/16/64. out_last exactly once per frame. elem resets to 0 on frame start.
- done asserts only after DRAIN completes, never concurrently with out_valid of the same frame.

Test Plan:
- Reset: drive rst=0 mid-stream with random inputs -> all outputs 0 immediately; after release, in_ready=0 until start.
- QPSK: s=00, start, feed 0x01,0x02,0x03,0x04 back-to-back, out_ready=1:
  - out_data=0x04030201, out_valid=1, out_last=1 one cycle after the 4th element.
  - done pulses the cycle after consumption; busy then 0.
- QAM16 with stall: s=01, feed elements 0..15, hold out_ready=0 after first word:
  - first word 0x03020100 held stable.
  - in_ready drops at lane 3 of the second word.
  - release -> words 0x07060504..0x0F0E0D0C in order, last on the 4th word only.
- QAM256 full rate: s=11, 256 elements, out_ready=1:
  - 64 words, throughput 1 element/cycle, out_last only on word 63 (0xFFFEFDFC).
  - done exactly once.
- Mode latch: start with s=10, flip s to 00 after 2 cycles -> frame still 64 elements (16 words); start pulses during the frame ignored.
- Abort: assert rst after 37 of 64 elements -> outputs cleared; new start with s=00 yields a clean single word with out_last.
